// File: rtl/ibex_clmul_iter.sv
// Iterative carry-less multiplier for CLMUL / CLMULH / CLMULR.
// Consumes BitsPerCycle bits of operand B per cycle, LSB chunk first.
module ibex_clmul_iter #(
    parameter int Width        = 32,
    parameter int BitsPerCycle = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       operator_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             kill_i,
    input  logic             ready_id_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Width-1:0] result_o
);

    localparam int N  = Width / BitsPerCycle;
    localparam int CW = $clog2(N) + 1;
    localparam int SH = $clog2(BitsPerCycle);
    localparam int BW = CW + SH;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [2*Width-1:0]   acc_q;
    logic [Width-1:0]     a_q, b_q;
    logic [1:0]           op_q;
    logic [CW-1:0]        cnt_q;

    logic [BW-1:0]        base;
    logic [2*Width-1:0]   a_base, pp;
    logic [Width-1:0]     b_shift;

    assign base = BW'(cnt_q) << SH;

    // Partial products of the current B chunk, already aligned to its bit offset
    always_comb begin
        a_base  = {{Width{1'b0}}, a_q} << base;
        b_shift = b_q >> base;
        pp      = '0;
        for (int j = 0; j < BitsPerCycle; j++) begin
            if (b_shift[j]) begin
                pp = pp ^ (a_base << j);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i) state_d = CALC;
            CALC:    if (cnt_q == LastCnt) state_d = DONE;
            DONE:    if (ready_id_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else if (kill_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        a_q   <= op_a_i;
                        b_q   <= op_b_i;
                        op_q  <= operator_i;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_q ^ pp;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE);

    always_comb begin
        result_o = '0;
        if (state_q == DONE) begin
            case (op_q)
                2'b00:   result_o = acc_q[Width-1:0];
                2'b01:   result_o = acc_q[2*Width-1:Width];
                2'b10:   result_o = acc_q[2*Width-2:Width-1];
                default: result_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_clmul_iter.sv
// Directed bench for ibex_clmul_iter plus a random sweep over three
// parameter sets against a bit-serial reference model.
module tb_ibex_clmul_iter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        en, kill, rdy;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, valid;
    logic [31:0] res;

    logic        sen;
    logic [1:0]  sop;
    logic [31:0] sa32, sb32;
    logic [63:0] sa64, sb64;
    logic        b1, v1, b32, v32, b64, v64;
    logic [31:0] r1, r32;
    logic [63:0] r64;

    int total = 0;
    int bad   = 0;

    ibex_clmul_iter #(.Width(32), .BitsPerCycle(4)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .operator_i(op),
        .op_a_i(a), .op_b_i(b), .kill_i(kill), .ready_id_i(rdy),
        .busy_o(busy), .valid_o(valid), .result_o(res)
    );

    ibex_clmul_iter #(.Width(32), .BitsPerCycle(1)) s1 (
        .clk_i(clk), .rst_i(rst), .en_i(sen), .operator_i(sop),
        .op_a_i(sa32), .op_b_i(sb32), .kill_i(1'b0), .ready_id_i(1'b1),
        .busy_o(b1), .valid_o(v1), .result_o(r1)
    );

    ibex_clmul_iter #(.Width(32), .BitsPerCycle(32)) s32 (
        .clk_i(clk), .rst_i(rst), .en_i(sen), .operator_i(sop),
        .op_a_i(sa32), .op_b_i(sb32), .kill_i(1'b0), .ready_id_i(1'b1),
        .busy_o(b32), .valid_o(v32), .result_o(r32)
    );

    ibex_clmul_iter #(.Width(64), .BitsPerCycle(8)) s64 (
        .clk_i(clk), .rst_i(rst), .en_i(sen), .operator_i(sop),
        .op_a_i(sa64), .op_b_i(sb64), .kill_i(1'b0), .ready_id_i(1'b1),
        .busy_o(b64), .valid_o(v64), .result_o(r64)
    );

    function automatic logic [63:0] ref_clmul(input logic [63:0] x,
                                              input logic [63:0] y,
                                              input logic [1:0]  o,
                                              input int          w);
        logic [127:0] p;
        logic [127:0] m;
        p = '0;
        m = (128'd1 << w) - 128'd1;
        for (int i = 0; i < w; i++) begin
            if (y[i]) p = p ^ ({64'd0, x} << i);
        end
        case (o)
            2'b00:   return 64'(p & m);
            2'b01:   return 64'((p >> w) & m);
            2'b10:   return 64'((p >> (w - 1)) & m);
            default: return 64'd0;
        endcase
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb,
                         input logic [1:0] top, input logic [31:0] exp,
                         input string nm);
        int lat;
        @(negedge clk);
        a = ta; b = tb; op = top; en = 1'b1; rdy = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL %s_lat: got %0d want 9", nm, lat);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL %s_res: got %h want %h", nm, res, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; kill = 1'b0; rdy = 1'b1;
        op = 2'b00; a = '0; b = '0;
        sen = 1'b0; sop = 2'b00; sa32 = '0; sb32 = '0; sa64 = '0; sb64 = '0;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b want 00", busy, valid);
        end
        total++;
        if (res !== 32'h0) begin
            bad++;
            $display("FAIL reset_res: got %h want 0", res);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timing();
        @(negedge clk);
        a = 32'h3; b = 32'h3; op = 2'b00; en = 1'b1; rdy = 1'b1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL t1_busy_c0: got %b want 0", busy);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
            total++;
            if (busy !== (c <= 9)) begin
                bad++;
                $display("FAIL t1_busy_c%0d: got %b want %b", c, busy, c <= 9);
            end
            total++;
            if (valid !== (c == 9)) begin
                bad++;
                $display("FAIL t1_valid_c%0d: got %b want %b", c, valid, c == 9);
            end
            if (c == 9) begin
                total++;
                if (res !== 32'h5) begin
                    bad++;
                    $display("FAIL t1_res: got %h want 00000005", res);
                end
            end
        end
    endtask

    task automatic test_vectors();
        do_op(32'h80000000, 32'h80000000, 2'b00, 32'h00000000, "msb_clmul");
        do_op(32'h80000000, 32'h80000000, 2'b01, 32'h40000000, "msb_clmulh");
        do_op(32'h80000000, 32'h80000000, 2'b10, 32'h80000000, "msb_clmulr");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h55555555, "ones_clmul");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h55555555, "ones_clmulh");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hAAAAAAAA, "ones_clmulr");
        do_op(32'h00000003, 32'h00000006, 2'b00, 32'h0000000A, "small");
        do_op(32'h12345678, 32'h00000000, 2'b00, 32'h00000000, "zero_b");
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        a = 32'h3; b = 32'h6; op = 2'b00; en = 1'b1; rdy = 1'b0;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            a = $urandom; b = $urandom;
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 9) begin
            bad++;
            $display("FAIL bp_lat: got %0d want 9", lat);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (valid !== 1'b1 || res !== 32'hA) begin
                bad++;
                $display("FAIL bp_hold%0d: got %b/%h want 1/0000000a", k, valid, res);
            end
            a = $urandom; b = $urandom;
            if (k < 2) @(negedge clk);
        end
        rdy = 1'b1; en = 1'b1; a = 32'h3; b = 32'h3;
        @(negedge clk);
        en = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle: got %b%b want 00", busy, valid);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_en_ignored: got %b want 0", busy);
        end
    endtask

    task automatic test_kill();
        int seen;
        @(negedge clk);
        a = 32'h3; b = 32'h3; op = 2'b00; en = 1'b1; rdy = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL kill_busy_c4: got %b want 1", busy);
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL kill_c5: got %b%b want 00", busy, valid);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL kill_novalid: got %0d want 0", seen);
        end
        do_op(32'h3, 32'h3, 2'b00, 32'h5, "kill_after");
        @(negedge clk);
        en = 1'b1; kill = 1'b1;
        @(negedge clk);
        en = 1'b0; kill = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL kill_en_c1: got %b want 0", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL kill_en_c2: got %b want 0", busy);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        @(negedge clk);
        a = 32'h3; b = 32'h3; op = 2'b00; en = 1'b1; rdy = 1'b0;
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_calc_pre: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || res !== 32'h0) begin
            bad++;
            $display("FAIL rst_calc: got %b%b/%h want 00/0", busy, valid, res);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a = 32'h3; b = 32'h3; op = 2'b00; en = 1'b1; rdy = 1'b0;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (valid !== 1'b1 || res !== 32'h5) begin
            bad++;
            $display("FAIL rst_done_pre: got %b/%h want 1/00000005", valid, res);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || res !== 32'h0) begin
            bad++;
            $display("FAIL rst_done: got %b%b/%h want 00/0", busy, valid, res);
        end
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h0, "reserved");
        do_op(32'h3, 32'h3, 2'b00, 32'h5, "post_reset");
    endtask

    task automatic test_sweep();
        logic [63:0] e32, e64;
        logic [31:0] q1, q32;
        logic [63:0] q64;
        int l1, l32, l64;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            sa32 = $urandom; sb32 = $urandom;
            sa64 = {$urandom, $urandom}; sb64 = {$urandom, $urandom};
            sop  = 2'($urandom_range(0, 3));
            sen  = 1'b1;
            e32  = ref_clmul({32'd0, sa32}, {32'd0, sb32}, sop, 32);
            e64  = ref_clmul(sa64, sb64, sop, 64);
            l1 = 0; l32 = 0; l64 = 0;
            q1 = '0; q32 = '0; q64 = '0;
            for (int c = 1; c <= 34; c++) begin
                @(negedge clk);
                if (c == 1) sen = 1'b0;
                if (v1 && l1 == 0) begin l1 = c; q1 = r1; end
                if (v32 && l32 == 0) begin l32 = c; q32 = r32; end
                if (v64 && l64 == 0) begin l64 = c; q64 = r64; end
            end
            total++;
            if (l1 !== 33 || q1 !== e32[31:0]) begin
                bad++;
                $display("FAIL bpc1 t%0d: got %0d/%h want 33/%h", t, l1, q1, e32[31:0]);
            end
            total++;
            if (l32 !== 2 || q32 !== e32[31:0]) begin
                bad++;
                $display("FAIL bpc32 t%0d: got %0d/%h want 2/%h", t, l32, q32, e32[31:0]);
            end
            total++;
            if (l64 !== 9 || q64 !== e64) begin
                bad++;
                $display("FAIL w64 t%0d: got %0d/%h want 9/%h", t, l64, q64, e64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_vectors();
        test_backpressure();
        test_kill();
        test_async_reset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
